// File: rtl/rgb_pwm_pkg.sv
// Shared types and default parameters for the RGB LED PWM sequencer.
package rgb_pwm_pkg;

    // Power sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WARMUP   = 2'd1,
        RUN      = 2'd2,
        SHUTDOWN = 2'd3
    } state_t;

    localparam int DEF_PWM_BITS      = 8;
    localparam int DEF_PRESCALE      = 12;
    localparam int DEF_SETTLE_CYCLES = 1200;

    // Width of a counter spanning 0..n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_pwm_tick.sv
// PWM prescaler: counts 0..PRESCALE-1 and pulses o_tick for one cycle on the
// last count. A synchronous clear holds it at zero with the tick suppressed.
module rgb_pwm_tick
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              W    = cnt_width(PRESCALE);
    localparam logic [W-1:0]    LAST = W'(PRESCALE - 1);

    logic [W-1:0] pre_q, pre_d;

    // Next prescaler value: wrap on the last count, hold at zero while cleared
    always_comb begin
        pre_d = pre_q;
        if (i_clr || (pre_q == LAST)) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // With PRESCALE=1 this fires every running cycle
    assign o_tick = !i_clr && (pre_q == LAST);

endmodule

// File: rtl/rgb_pwm_seq.sv
// RGB LED PWM sequencer: powers up the current reference, waits for it to
// settle, enables the RGB driver and generates three PWM channels. Duty
// updates arrive over valid/ready and are only swapped in at period
// boundaries while running, so a PWM period is never cut short or stretched.
module rgb_pwm_seq
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS      = DEF_PWM_BITS,
    parameter int PRESCALE      = DEF_PRESCALE,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [PWM_BITS-1:0] i_duty_r,
    input  logic [PWM_BITS-1:0] i_duty_g,
    input  logic [PWM_BITS-1:0] i_duty_b,
    input  logic                i_duty_valid,
    output logic                o_duty_ready,
    output logic                o_drv_en,
    output logic                o_rgb_en,
    output logic                o_pwm_r,
    output logic                o_pwm_g,
    output logic                o_pwm_b,
    output logic                o_running
);

    // Counter runs 0..2^N-2 so a duty of 2^N-1 is high for the whole period
    localparam logic [PWM_BITS-1:0] CNT_LAST    = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam int                  SW          = cnt_width(SETTLE_CYCLES);
    localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t                      state_q, state_d;
    logic [SW-1:0]               settle_q, settle_d;
    logic [PWM_BITS-1:0]         cnt_q, cnt_d;

    // Channel order in the packed duty arrays: [0]=red, [1]=green, [2]=blue
    logic [2:0][PWM_BITS-1:0]    act_q, act_d;
    logic [2:0][PWM_BITS-1:0]    pend_q, pend_d;
    logic [2:0][PWM_BITS-1:0]    duty_in;
    logic                        pend_vld_q, pend_vld_d;
    logic                        ready_q, ready_d;

    logic                        drv_en_q, drv_en_d;
    logic                        rgb_en_q, rgb_en_d;
    logic                        running_q, running_d;
    logic [2:0]                  pwm_q, pwm_d;

    logic                        tick;
    logic                        boundary;
    logic                        xfer;

    assign duty_in  = {i_duty_b, i_duty_g, i_duty_r};
    assign xfer     = i_duty_valid && ready_q;
    // The wrap tick closes a period; tick is already gated to RUN
    assign boundary = tick && (cnt_q == CNT_LAST);

    rgb_pwm_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (state_q != RUN),
        .o_tick (tick)
    );

    // Power sequencing: next state, settle timer and the enables it decodes to
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = WARMUP;
                end
            end
            WARMUP: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RUN: begin
                if (!i_enable) begin
                    state_d = SHUTDOWN;
                end
            end
            SHUTDOWN: begin
                // Always lands in IDLE for one cycle, even if re-enabled
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Enables are decoded from the next state so they register in step
        // with the state itself
        drv_en_d  = (state_d != IDLE);
        rgb_en_d  = (state_d == RUN);
        running_d = (state_d == RUN);
    end

    // PWM period counter: advances per tick, restarts at zero on RUN entry
    always_comb begin
        cnt_d = '0;
        if (state_q == RUN) begin
            cnt_d = cnt_q;
            if (tick) begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // Duty handshake: direct load outside RUN, staged through pending in RUN
    always_comb begin
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (state_q != RUN) begin
            // A triple staged just before leaving RUN is committed here so it
            // is not lost; ready is low then, so no new transfer can collide
            if (pend_vld_q) begin
                act_d      = pend_q;
                pend_vld_d = 1'b0;
            end else if (xfer) begin
                act_d = duty_in;
            end
        end else begin
            if (boundary && pend_vld_q) begin
                act_d      = pend_q;
                pend_vld_d = 1'b0;
            end
            // A transfer on a boundary cycle waits for the next boundary
            if (xfer) begin
                pend_d     = duty_in;
                pend_vld_d = 1'b1;
            end
        end
        ready_d = !pend_vld_d;
    end

    // Comparators on next-cycle values so the registered PWM lines up with
    // the counter and a new duty takes effect exactly at cnt=0
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < 3; i++) begin
            pwm_d[i] = (state_d == RUN) && (cnt_d < act_d[i]);
        end
    end

    // Sequencer and counter state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
        end
    end

    // Duty registers and handshake flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ready_q    <= ready_d;
        end
    end

    // Output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drv_en_q  <= 1'b0;
            rgb_en_q  <= 1'b0;
            running_q <= 1'b0;
            pwm_q     <= '0;
        end else begin
            drv_en_q  <= drv_en_d;
            rgb_en_q  <= rgb_en_d;
            running_q <= running_d;
            pwm_q     <= pwm_d;
        end
    end

    assign o_duty_ready = ready_q;
    assign o_drv_en     = drv_en_q;
    assign o_rgb_en     = rgb_en_q;
    assign o_running    = running_q;
    assign o_pwm_r      = pwm_q[0];
    assign o_pwm_g      = pwm_q[1];
    assign o_pwm_b      = pwm_q[2];

endmodule

// File: tb/tb_rgb_pwm_seq.sv
// Self-checking bench for rgb_pwm_seq with PWM_BITS=4, PRESCALE=2,
// SETTLE_CYCLES=8. Every cycle is compared against a timing model that
// derives the PWM phase arithmetically from cycles spent in RUN.
module tb_rgb_pwm_seq;

    localparam int NB   = 4;
    localparam int PRE  = 2;
    localparam int SET  = 8;
    localparam int NCNT = (1 << NB) - 1;   // counter values per period
    localparam int PER  = NCNT * PRE;      // clock cycles per period

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_enable;
    logic [NB-1:0] i_duty_r, i_duty_g, i_duty_b;
    logic          i_duty_valid;
    logic          o_duty_ready, o_drv_en, o_rgb_en;
    logic          o_pwm_r, o_pwm_g, o_pwm_b, o_running;

    always #5 i_clk = ~i_clk;

    rgb_pwm_seq #(
        .PWM_BITS      (NB),
        .PRESCALE      (PRE),
        .SETTLE_CYCLES (SET)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_duty_r     (i_duty_r),
        .i_duty_g     (i_duty_g),
        .i_duty_b     (i_duty_b),
        .i_duty_valid (i_duty_valid),
        .o_duty_ready (o_duty_ready),
        .o_drv_en     (o_drv_en),
        .o_rgb_en     (o_rgb_en),
        .o_pwm_r      (o_pwm_r),
        .o_pwm_g      (o_pwm_g),
        .o_pwm_b      (o_pwm_b),
        .o_running    (o_running)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 off, 1 warming, 2 running, 3 shutting down
    int m_mode, m_warm, m_run_t;
    int m_act[3], m_pend[3];
    bit m_pv;

    function automatic void model_reset();
        m_mode = 0; m_warm = 0; m_run_t = 0; m_pv = 0;
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_pend[i] = 0;
        end
    endfunction

    // Advance by one clock using the inputs presented for that edge
    function automatic void model_step();
        int  din[3];
        bit  xfer;
        bit  bnd;
        din[0] = int'(i_duty_r); din[1] = int'(i_duty_g); din[2] = int'(i_duty_b);
        xfer = i_duty_valid && !m_pv;
        bnd  = (m_mode == 2) && ((m_run_t % PER) == PER - 1);
        if (m_mode != 2) begin
            if (m_pv) begin
                m_act = m_pend; m_pv = 0;
            end else if (xfer) begin
                m_act = din;
            end
        end else begin
            if (bnd && m_pv) begin
                m_act = m_pend; m_pv = 0;
            end
            if (xfer) begin
                m_pend = din; m_pv = 1;
            end
        end
        case (m_mode)
            0: if (i_enable) begin m_mode = 1; m_warm = 0; end
            1: if (!i_enable) m_mode = 0;
               else if (m_warm == SET - 1) begin m_mode = 2; m_run_t = 0; end
               else m_warm++;
            2: if (!i_enable) m_mode = 3; else m_run_t++;
            default: m_mode = 0;
        endcase
    endfunction

    // {drv_en, rgb_en, running, r, g, b, ready}
    function automatic logic [6:0] exp_vec();
        logic [2:0] p;
        for (int i = 0; i < 3; i++)
            p[2 - i] = (m_mode == 2) && (((m_run_t / PRE) % NCNT) < m_act[i]);
        return {m_mode != 0, m_mode == 2, m_mode == 2, p, !m_pv};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {o_drv_en, o_rgb_en, o_running, o_pwm_r, o_pwm_g, o_pwm_b, o_duty_ready};
    endfunction

    // One clock: inputs are already set (we sit at a falling edge)
    task automatic cyc(input string name);
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check(name, dut_vec(), exp_vec());
    endtask

    task automatic set_duty(input int r, input int g, input int b, input logic v);
        i_duty_r = NB'(r); i_duty_g = NB'(g); i_duty_b = NB'(b); i_duty_valid = v;
    endtask

    task automatic goto_idle();
        i_enable = 1'b0;
        repeat (3) cyc("to_idle");
    endtask

    task automatic goto_run();
        i_enable = 1'b1;
        repeat (SET + 1) cyc("to_run");
    endtask

    typedef struct {
        int r, g, b;
        int hr, hg, hb;   // expected high cycles per period
    } vec_t;
    vec_t tbl[4];

    int c, hr, hg, hb, acc;

    initial begin
        tbl[0] = '{0, 5, 15, 0, 10, 30};
        tbl[1] = '{8, 8, 8, 16, 16, 16};
        tbl[2] = '{1, 14, 7, 2, 28, 14};
        tbl[3] = '{15, 0, 3, 30, 0, 6};

        // Reset state
        i_rst = 1'b1; i_enable = 1'b0;
        set_duty(0, 0, 0, 1'b0);
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        check("reset_outputs", dut_vec(), 7'b0000001);
        i_rst = 1'b0;

        // Power-up timing: drv_en after 1 cycle, rgb_en 8 cycles later
        i_enable = 1'b1;
        for (int k = 1; k <= SET + 1; k++) begin
            cyc("t1");
            check("t1_drv_en", o_drv_en, 1'b1);
            check("t1_rgb_en", o_rgb_en, (k == SET + 1));
        end
        acc = 0;
        repeat (PER) begin
            acc += o_pwm_r + o_pwm_g + o_pwm_b;
            cyc("t1_run");
        end
        check("t1_pwm_zero", acc, 0);

        // Duty table: load in IDLE, measure high time over one period
        foreach (tbl[i]) begin
            goto_idle();
            set_duty(tbl[i].r, tbl[i].g, tbl[i].b, 1'b1);
            cyc("tbl_load");
            i_duty_valid = 1'b0;
            goto_run();
            hr = 0; hg = 0; hb = 0;
            repeat (PER) begin
                hr += o_pwm_r; hg += o_pwm_g; hb += o_pwm_b;
                cyc("tbl_run");
            end
            check("tbl_hi_r", hr, tbl[i].hr);
            check("tbl_hi_g", hg, tbl[i].hg);
            check("tbl_hi_b", hb, tbl[i].hb);
        end

        // Mid-period update: held until the boundary
        goto_idle();
        set_duty(0, 5, 15, 1'b1);
        cyc("t3_load");
        i_duty_valid = 1'b0;
        goto_run();
        repeat (10) cyc("t3_pre");
        set_duty(8, 8, 8, 1'b1);
        cyc("t3_offer");
        i_duty_valid = 1'b0;
        check("t3_ready_drop", o_duty_ready, 1'b0);
        c = 0;
        for (int i = 0; i < 2 * PER && o_duty_ready === 1'b0; i++) begin
            c++;
            cyc("t3_wait");
        end
        check("t3_ready_low_cycles", c, PER - 1 - 10);
        hr = 0; hg = 0; hb = 0;
        repeat (PER) begin
            hr += o_pwm_r; hg += o_pwm_g; hb += o_pwm_b;
            cyc("t3_new");
        end
        check("t3_hi_r", hr, 16);
        check("t3_hi_g", hg, 16);
        check("t3_hi_b", hb, 16);

        // Update offered on the boundary cycle: one full old period first
        repeat (PER - 1) cyc("t4_pre");
        set_duty(3, 12, 1, 1'b1);
        cyc("t4_offer");
        i_duty_valid = 1'b0;
        c = 0; hg = 0;
        for (int i = 0; i < 2 * PER && o_duty_ready === 1'b0; i++) begin
            c++;
            hg += o_pwm_g;
            cyc("t4_wait");
        end
        check("t4_ready_low_cycles", c, PER);
        check("t4_old_period_g", hg, 16);
        hr = 0; hg = 0; hb = 0;
        repeat (PER) begin
            hr += o_pwm_r; hg += o_pwm_g; hb += o_pwm_b;
            cyc("t4_new");
        end
        check("t4_hi_r", hr, 6);
        check("t4_hi_g", hg, 24);
        check("t4_hi_b", hb, 2);

        // Shutdown from RUN
        i_enable = 1'b0;
        cyc("t5_sd1");
        check("t5_rgb_off", o_rgb_en, 1'b0);
        check("t5_drv_hold", o_drv_en, 1'b1);
        check("t5_pwm_off", {o_pwm_r, o_pwm_g, o_pwm_b}, 3'b000);
        cyc("t5_sd2");
        check("t5_drv_off", o_drv_en, 1'b0);

        // Abort during warm-up at settle count 4
        i_enable = 1'b1;
        acc = 0;
        repeat (5) begin
            cyc("t5_warm");
            acc += o_rgb_en;
        end
        i_enable = 1'b0;
        cyc("t5_abort");
        acc += o_rgb_en;
        check("t5_abort_drv", o_drv_en, 1'b0);
        repeat (SET + 2) begin
            cyc("t5_idle");
            acc += o_rgb_en;
        end
        check("t5_rgb_never", acc, 0);

        // Re-enable during SHUTDOWN still passes through IDLE
        goto_run();
        i_enable = 1'b0;
        cyc("t5_re_sd");
        i_enable = 1'b1;
        cyc("t5_re_idle");
        check("t5_re_idle_drv", o_drv_en, 1'b0);
        cyc("t5_re_warm");
        check("t5_re_warm_drv", o_drv_en, 1'b1);
        repeat (SET) cyc("t5_re_run");

        // Async reset mid-RUN with an update pending
        goto_idle();
        set_duty(15, 15, 15, 1'b1);
        cyc("t6_load");
        i_duty_valid = 1'b0;
        goto_run();
        repeat (3) cyc("t6_run");
        set_duty(5, 5, 5, 1'b1);
        cyc("t6_offer");
        i_duty_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1 check("t6_async_reset", dut_vec(), 7'b0000001);
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        goto_run();
        acc = 0;
        repeat (PER) begin
            acc += o_pwm_r + o_pwm_g + o_pwm_b;
            cyc("t6_rerun");
        end
        check("t6_duty_cleared", acc, 0);

        // Random traffic against the model
        i_enable = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) i_enable = ~i_enable;
            set_duty(($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15),
                     ($urandom_range(0, 3) == 0) ? 0  : $urandom_range(0, 15),
                     $urandom_range(0, 15),
                     ($urandom_range(0, 3) == 0));
            cyc("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
